// File: rtl/fetch_stage.sv
// Generic N-bit two-operand adder, wrap-around on overflow.
// Latency: combinational.
// Backpressure: none.
module adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_sum
);
    assign o_sum = i_a + i_b;
endmodule

// Instruction fetch: owns the PC, drives the imem handshake, loads the IF/ID register.
// Latency: fetched word appears on o_ifid_* one edge after the accepting cycle.
// Backpressure: imem wait states hold req/addr stable; i_stall holds PC and IF/ID.
module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic                  i_redirect,
    input  logic [DATA_WIDTH-1:0] i_redirect_pc,
    output logic                  o_imem_req,
    output logic [DATA_WIDTH-1:0] o_imem_addr,
    input  logic                  i_imem_ready,
    input  logic [DATA_WIDTH-1:0] i_imem_rdata,
    output logic                  o_ifid_valid,
    output logic [DATA_WIDTH-1:0] o_ifid_pc,
    output logic [DATA_WIDTH-1:0] o_ifid_pc_plus4,
    output logic [DATA_WIDTH-1:0] o_ifid_instr
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_KILL} state_t;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] pc_plus4;
        logic [DATA_WIDTH-1:0] instr;
    } ifid_t;

    localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MK = ~DATA_WIDTH'(3);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] pending_q, pending_d;
    ifid_t                 ifid_q, ifid_d;

    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] redirect_tgt;
    logic                  accept;

    adder #(.N(DATA_WIDTH)) u_pc_adder (
        .i_a   (pc_q),
        .i_b   (PC_STEP),
        .o_sum (pc_plus4)
    );

    assign redirect_tgt = i_redirect_pc & ALIGN_MK;

    // Request depends on state only, so it is stable across memory wait states.
    assign o_imem_req  = (state_q != S_IDLE);
    assign o_imem_addr = pc_q;
    assign accept      = o_imem_req && i_imem_ready;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = pending_q;
        ifid_d    = ifid_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (accept) begin
                    if (i_redirect) begin
                        pc_d         = redirect_tgt;
                        ifid_d.valid = 1'b0;
                    end else if (!i_stall) begin
                        pc_d   = pc_plus4;
                        ifid_d = '{valid: 1'b1, pc: pc_q, pc_plus4: pc_plus4,
                                   instr: i_imem_rdata};
                    end
                end else begin
                    if (i_redirect) begin
                        pending_d = redirect_tgt;
                        state_d   = S_KILL;
                    end
                    if (!i_stall) begin
                        ifid_d.valid = 1'b0;
                    end
                end
            end
            S_KILL: begin
                // The in-flight word belongs to the wrong path; newest redirect wins.
                if (i_redirect) begin
                    pending_d = redirect_tgt;
                end
                if (accept) begin
                    pc_d    = i_redirect ? redirect_tgt : pending_q;
                    state_d = S_RUN;
                end
                if (!i_stall) begin
                    ifid_d.valid = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (i_flush) begin
            ifid_d.valid = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            pending_q <= '0;
            ifid_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
            ifid_q    <= ifid_d;
        end
    end

    assign o_ifid_valid    = ifid_q.valid;
    assign o_ifid_pc       = ifid_q.pc;
    assign o_ifid_pc_plus4 = ifid_q.pc_plus4;
    assign o_ifid_instr    = ifid_q.instr;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vectors, a fetch-stream reference model and a second
// instance with a wrapping reset PC.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall, flush, redirect, ready;
    logic [31:0] rpc, data_ofs;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_pc, ifid_pc4, ifid_instr;

    logic        z_stall, z_flush, z_redirect, z_ready;
    logic [31:0] z_rpc;
    logic        d2_req;
    logic [31:0] d2_addr, d2_rdata;
    logic        d2_valid;
    logic [31:0] d2_pc, d2_pc4, d2_instr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr + data_ofs;
    assign d2_rdata   = d2_addr;

    fetch_stage dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush),
        .i_redirect(redirect), .i_redirect_pc(rpc),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr),
        .i_imem_ready(ready), .i_imem_rdata(imem_rdata),
        .o_ifid_valid(ifid_valid), .o_ifid_pc(ifid_pc),
        .o_ifid_pc_plus4(ifid_pc4), .o_ifid_instr(ifid_instr)
    );

    fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(z_stall), .i_flush(z_flush),
        .i_redirect(z_redirect), .i_redirect_pc(z_rpc),
        .o_imem_req(d2_req), .o_imem_addr(d2_addr),
        .i_imem_ready(z_ready), .i_imem_rdata(d2_rdata),
        .o_ifid_valid(d2_valid), .o_ifid_pc(d2_pc),
        .o_ifid_pc_plus4(d2_pc4), .o_ifid_instr(d2_instr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference: the fetch stream as "address in flight", "that fetch is doomed, go to
    // target afterwards", and the decoded slot contents.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } slot_t;

    logic        m_on, m_drop;
    logic [31:0] m_pc, m_tgt;
    slot_t       m_if;

    function automatic logic [31:0] align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_on   <= 1'b0;
            m_drop <= 1'b0;
            m_pc   <= 32'h0;
            m_tgt  <= 32'h0;
            m_if   <= '0;
        end else begin
            if (!m_on) begin
                m_on <= 1'b1;
            end else if (m_drop) begin
                if (ready) begin
                    m_pc   <= redirect ? align(rpc) : m_tgt;
                    m_drop <= 1'b0;
                end else if (redirect) begin
                    m_tgt <= align(rpc);
                end
                if (!stall) m_if.valid <= 1'b0;
            end else if (ready) begin
                if (redirect) begin
                    m_pc       <= align(rpc);
                    m_if.valid <= 1'b0;
                end else if (!stall) begin
                    m_if <= '{valid: 1'b1, pc: m_pc, pc4: m_pc + 32'd4,
                              instr: m_pc + data_ofs};
                    m_pc <= m_pc + 32'd4;
                end
            end else begin
                if (redirect) begin
                    m_drop <= 1'b1;
                    m_tgt  <= align(rpc);
                end
                if (!stall) m_if.valid <= 1'b0;
            end
            if (flush) m_if.valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("model_req", {31'b0, imem_req}, {31'b0, m_on});
        chk("model_addr", imem_addr, m_pc);
        chk("model_valid", {31'b0, ifid_valid}, {31'b0, m_if.valid});
        if (m_if.valid) begin
            chk("model_pc", ifid_pc, m_if.pc);
            chk("model_pc4", ifid_pc4, m_if.pc4);
            chk("model_instr", ifid_instr, m_if.instr);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_slot(input string name, input logic [31:0] pc,
                            input logic [31:0] pc4, input logic [31:0] instr);
        chk({name, "_valid"}, {31'b0, ifid_valid}, 32'd1);
        chk({name, "_pc"}, ifid_pc, pc);
        chk({name, "_pc4"}, ifid_pc4, pc4);
        chk({name, "_instr"}, ifid_instr, instr);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_req"}, {31'b0, imem_req}, 32'd0);
        chk({name, "_addr"}, imem_addr, 32'h0);
        chk({name, "_valid"}, {31'b0, ifid_valid}, 32'd0);
        chk({name, "_pc"}, ifid_pc, 32'h0);
        chk({name, "_pc4"}, ifid_pc4, 32'h0);
        chk({name, "_instr"}, ifid_instr, 32'h0);
    endtask

    initial begin
        stall = 0; flush = 0; redirect = 0; ready = 1; rpc = 0; data_ofs = 0;
        z_stall = 0; z_flush = 0; z_redirect = 0; z_ready = 1; z_rpc = 0;
        #1 rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst");
        chk("rst_d2_addr", d2_addr, 32'hFFFF_FFF8);
        step(); step();
        rst_n = 1'b1;
        chk("idle_req", {31'b0, imem_req}, 32'd0);

        step(); // first request
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        chk("first_valid", {31'b0, ifid_valid}, 32'd0);
        step();
        chk_slot("seq0", 32'h0, 32'h4, 32'h0);
        chk("d2_pc0", d2_pc, 32'hFFFF_FFF8);
        chk("d2_pc4_0", d2_pc4, 32'hFFFF_FFFC);
        step();
        chk_slot("seq1", 32'h4, 32'h8, 32'h4);
        chk("d2_pc1", d2_pc, 32'hFFFF_FFFC);
        chk("d2_pc4_1", d2_pc4, 32'h0);
        chk("seq1_addr", imem_addr, 32'h8);

        stall = 1;
        step();
        chk("stall_addr", imem_addr, 32'h8);
        chk_slot("stall_hold", 32'h4, 32'h8, 32'h4);
        chk("d2_pc2", d2_pc, 32'h0);
        step(); step();
        chk("stall3_addr", imem_addr, 32'h8);
        chk("stall3_pc", ifid_pc, 32'h4);
        stall = 0;
        step();
        chk_slot("unstall", 32'h8, 32'hC, 32'h8);
        step();
        chk("pre_redir_addr", imem_addr, 32'h10);

        redirect = 1; rpc = 32'h102;
        step();
        redirect = 0;
        chk("redir_bubble", {31'b0, ifid_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'h100);
        step();
        chk_slot("redir_tgt", 32'h100, 32'h104, 32'h100);

        data_ofs = 32'h1000_0000;
        redirect = 1; rpc = 32'h20;
        step();
        chk("to20_addr", imem_addr, 32'h20);
        rpc = 32'h200; ready = 0;
        step();
        chk("wait1_addr", imem_addr, 32'h20);
        chk("wait1_req", {31'b0, imem_req}, 32'd1);
        rpc = 32'h300;
        step();
        chk("wait2_addr", imem_addr, 32'h20);
        redirect = 0; ready = 1;
        step();
        chk("kill_addr", imem_addr, 32'h300);
        chk("kill_drop", {31'b0, ifid_valid}, 32'd0);
        step();
        chk_slot("kill_tgt", 32'h300, 32'h304, 32'h1000_0300);

        flush = 1; stall = 1;
        step();
        chk("flst_valid", {31'b0, ifid_valid}, 32'd0);
        chk("flst_addr", imem_addr, 32'h304);
        flush = 0; stall = 0;
        step();
        chk("after_flst_pc", ifid_pc, 32'h304);
        flush = 1;
        step();
        flush = 0;
        chk("flush_valid", {31'b0, ifid_valid}, 32'd0);
        chk("flush_addr", imem_addr, 32'h30C);

        ready = 0;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        step(); step();
        rst_n = 1'b1;
        ready = 1;
        chk("rerel_req", {31'b0, imem_req}, 32'd0);
        step();
        chk("restart_req", {31'b0, imem_req}, 32'd1);
        chk("restart_addr", imem_addr, 32'h0);
        step();
        chk("restart_pc", ifid_pc, 32'h0);

        for (int i = 0; i < 150; i++) begin
            ready    = ((i % 5) != 3) && ((i % 7) != 2);
            stall    = ((i % 11) == 4);
            flush    = ((i % 13) == 6);
            redirect = !stall && (((i % 9) == 1) || ((i % 17) == 8));
            rpc      = 32'h400 + 32'(i) * 32'd16 + 32'(i % 4);
            step();
        end
        ready = 1; stall = 0; flush = 0; redirect = 0;
        step(); step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
